spi_receiver: RTL and testbench

- Serial-to-parallel receiver: the far end of the team's SPI link. It accepts cs/scl/sda from an SPI transmitter and assembles MSB-first bytes.
- Each byte is presented on a one-entry holding register with a valid/ack handshake. Frame errors and overruns are reported.
- Sits on the peripheral/controller side, fully synchronous to the local clk. scl is sampled as data, never used as a clock.

---
 rtl/spi_receiver_pkg.sv | 11 +
 rtl/spi_receiver_sync_ff.sv | 19 +
 rtl/spi_receiver.sv | 108 ++++++++++
 tb/tb_spi_receiver.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/spi_receiver_pkg.sv
// Shared constants and FSM encoding for the SPI receive path.
package spi_receiver_pkg;
   localparam int CLK_FREQ       = 100_000_000;
   localparam int SPI_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      SPI_RX_IDLE  = 2'd0,
      SPI_RX_SHIFT = 2'd1,
      SPI_RX_LOAD  = 2'd2
   } spi_rx_state_e;
endpackage

// File: rtl/spi_receiver_sync_ff.sv
// Multi-stage synchroniser; reset value chosen per signal so idle levels survive reset.
module sync_ff #(
   parameter int   DEPTH   = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic [DEPTH-1:0] chain_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) chain_q <= {DEPTH{RST_VAL}};
      else        chain_q <= {chain_q[DEPTH-2:0], d_i};
   end

   assign q_o = chain_q[DEPTH-1];
endmodule

// File: rtl/spi_receiver.sv
// SPI slave receiver: oversamples cs/scl/sda on clk, assembles words, one-entry valid/ack holding register.
module spi_receiver
   import spi_receiver_pkg::*;
#(
   parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic                  scl,
   input  logic                  sda,
   input  logic                  ack,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  overrun
);
   localparam int                CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   logic cs_s, scl_s, sda_s, scl_q, scl_rise;
   spi_rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]      bitcnt_q, bitcnt_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d, data_q, data_d;
   logic                  valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;

   sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs  (.clk(clk), .reset(reset), .d_i(cs),  .q_o(cs_s));
   sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_scl (.clk(clk), .reset(reset), .d_i(scl), .q_o(scl_s));
   sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sda (.clk(clk), .reset(reset), .d_i(sda), .q_o(sda_s));

   assign scl_rise = scl_s & ~scl_q;

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      valid_d  = valid_q;
      ferr_d   = 1'b0;
      ovr_d    = ovr_q;
      if (valid_q && ack) valid_d = 1'b0;
      case (state_q)
         SPI_RX_IDLE: begin
            bitcnt_d = '0;
            if (!cs_s) state_d = SPI_RX_SHIFT;
         end
         SPI_RX_SHIFT: begin
            // cs release wins over a coincident scl edge; a partial word is dropped
            if (cs_s) begin
               ferr_d   = (bitcnt_q != '0);
               bitcnt_d = '0;
               state_d  = SPI_RX_IDLE;
            end else if (scl_rise) begin
               shreg_d = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], sda_s}
                                   : {sda_s, shreg_q[DATA_WIDTH-1:1]};
               if (bitcnt_q == LAST_BIT) begin
                  bitcnt_d = '0;
                  state_d  = SPI_RX_LOAD;
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end
         end
         SPI_RX_LOAD: begin
            // an ack in this cycle frees the slot, so the new word replaces the old one
            if (!valid_q || ack) begin
               data_d  = shreg_q;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
            state_d = cs_s ? SPI_RX_IDLE : SPI_RX_SHIFT;
         end
         default: state_d = SPI_RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= SPI_RX_IDLE;
         bitcnt_q <= '0;
         shreg_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
         scl_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shreg_q  <= shreg_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
         scl_q    <= scl_s;
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign busy      = (state_q != SPI_RX_IDLE);
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
endmodule

// File: tb/tb_spi_receiver.sv
// Randomised bench for spi_receiver: MSB-first and LSB-first instances share one bus, checked against a byte-level model.
module tb_spi_receiver;
   logic clk = 1'b0, reset = 1'b0, cs = 1'b1, scl = 1'b0, sda = 1'b0, ack = 1'b0;
   logic [7:0] dout_m, dout_l;
   logic valid_m, valid_l, busy_m, busy_l, ferr_m, ferr_l, ovr_m, ovr_l;

   int n_checks = 0, n_fail = 0, frame_bits = 0;
   logic [7:0] ed [2];
   bit         ev [2];
   bit         eo [2];

   spi_receiver #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .cs(cs), .scl(scl), .sda(sda), .ack(ack),
      .data_out(dout_m), .valid(valid_m), .busy(busy_m), .frame_err(ferr_m), .overrun(ovr_m));
   spi_receiver #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .cs(cs), .scl(scl), .sda(sda), .ack(ack),
      .data_out(dout_l), .valid(valid_l), .busy(busy_l), .frame_err(ferr_l), .overrun(ovr_l));

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic model_reset;
      for (int i = 0; i < 2; i++) begin ed[i] = '0; ev[i] = 0; eo[i] = 0; end
      frame_bits = 0;
   endtask

   // bits go out v[7] first; the LSB-first instance therefore sees the bit-reversed value
   task automatic model_load(input logic [7:0] v, input bit acked);
      logic [7:0] w [2];
      w[0] = v; w[1] = rev8(v);
      for (int i = 0; i < 2; i++)
         if (!ev[i] || acked) begin ed[i] = w[i]; ev[i] = 1; end
         else eo[i] = 1;
   endtask

   task automatic check_outs(input string tag);
      chk({tag, "/data_m"}, dout_m, ed[0]);
      chk({tag, "/data_l"}, dout_l, ed[1]);
      chk({tag, "/valid_m"}, valid_m, ev[0]);
      chk({tag, "/valid_l"}, valid_l, ev[1]);
      chk({tag, "/ovr_m"}, ovr_m, eo[0]);
      chk({tag, "/ovr_l"}, ovr_l, eo[1]);
   endtask

   task automatic cs_begin;
      cs = 1'b0;
      frame_bits = 0;
      repeat (4) tick;
      chk("busy_m", busy_m, 1);
      chk("busy_l", busy_l, 1);
   endtask

   task automatic cs_end;
      cs = 1'b1;
      repeat (3) tick;
      chk("ferr_m", ferr_m, (frame_bits % 8) != 0);
      chk("ferr_l", ferr_l, (frame_bits % 8) != 0);
      tick;
      chk("ferr_end", ferr_m | ferr_l, 0);
      chk("idle_busy", busy_m | busy_l, 0);
      check_outs("cs_end");
   endtask

   task automatic ack_pulse;
      ack = 1'b1;
      tick;
      ack = 1'b0;
      for (int i = 0; i < 2; i++) if (ev[i]) ev[i] = 0;
      check_outs("ack");
   endtask

   // the 8th rising edge lands the word 4 clk edges later; ack_load holds ack through the LOAD cycle
   task automatic send_byte(input logic [7:0] v, input int nbits, input bit ack_load);
      int h;
      for (int i = 0; i < nbits; i++) begin
         sda = v[7-i];
         repeat (2) tick;
         scl = 1'b1;
         frame_bits++;
         h = $urandom_range(5, 8);
         if (i == 7) begin
            repeat (3) tick;
            chk("preload_vm", valid_m, ev[0]);
            chk("preload_vl", valid_l, ev[1]);
            ack = ack_load;
            tick;
            ack = 1'b0;
            model_load(v, ack_load);
            check_outs("load");
            repeat (h - 4) tick;
         end else begin
            repeat (h) tick;
         end
         scl = 1'b0;
         repeat ($urandom_range(4, 8)) tick;
      end
   endtask

   initial begin
      model_reset();
      repeat (3) tick;
      check_outs("reset");
      chk("reset_busy", busy_m | busy_l, 0);
      chk("reset_ferr", ferr_m | ferr_l, 0);
      reset = 1'b1;
      repeat (3) tick;

      cs_begin(); send_byte(8'hA5, 8, 0); cs_end(); ack_pulse();

      cs_begin(); send_byte(8'h3C, 8, 0); ack_pulse(); send_byte(8'hC3, 8, 0); ack_pulse(); cs_end();

      cs_begin(); send_byte(8'h11, 8, 0); send_byte(8'h22, 8, 0); cs_end(); ack_pulse();

      cs_begin(); send_byte(8'hE7, 5, 0); cs_end();
      cs_begin(); send_byte(8'h5A, 8, 0); cs_end(); ack_pulse();

      cs_begin(); send_byte(8'hFF, 4, 0);
      reset = 1'b0;
      #1;
      model_reset();
      check_outs("async_rst");
      chk("async_rst_busy", busy_m | busy_l, 0);
      cs = 1'b1; scl = 1'b0; sda = 1'b0;
      tick; reset = 1'b1; repeat (3) tick;
      cs_begin(); send_byte(8'hFF, 8, 0); cs_end(); ack_pulse();

      // 0x80 sent MSB-first is 1,0,...,0 on the wire: 0x01 for the LSB-first instance
      cs_begin(); send_byte(8'h80, 8, 0); send_byte(8'h37, 8, 1); cs_end(); ack_pulse();

      for (int f = 0; f < 20; f++) begin
         int nb;
         nb = $urandom_range(1, 3);
         cs_begin();
         for (int b = 0; b < nb; b++) begin
            logic [7:0] v;
            int mode;
            v = 8'($urandom);
            mode = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) begin
               send_byte(v, $urandom_range(1, 7), 0);
               break;
            end
            send_byte(v, 8, mode == 2);
            if (mode == 1) ack_pulse();
         end
         cs_end();
         if ($urandom_range(0, 1) == 1) ack_pulse();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
